// File: rtl/sbox_share_sched.sv
// Shares one external 6-to-4 DES S-box across the eight S-box positions,
// issuing one lookup per cycle and assembling the 32-bit S-layer result.
module sbox_share_sched #(
    parameter int SBOX_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] din,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dout,
    output logic [2:0]  sbox_sel,
    output logic [5:0]  sbox_in,
    output logic        sbox_req,
    input  logic [3:0]  sbox_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      r_state;
    logic [2:0]  r_k;
    logic [47:0] r_din;
    logic [31:0] r_dout;
    logic        r_col_vld;
    logic [2:0]  r_col_sel;

    logic        w_run;
    logic        w_accept;
    logic        w_col_vld;
    logic [2:0]  w_col_sel;
    logic [5:0]  w_sh;
    logic [5:0]  w_raw;
    logic [3:0]  w_nib;
    logic [31:0] w_dout_nxt;

    assign w_run     = (r_state == RUN);
    assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == DONE);
    assign busy      = w_run | (r_state == DRAIN);
    assign dout      = r_dout;

    // Bit 0 of din/dout is the DES MSB, so each chunk is bit-reversed on the way
    // to and from the S-box, whose ports use ordinary MSB-high numbering.
    assign w_sh     = 6'(r_k) * 6'd6;
    assign w_raw    = r_din[w_sh +: 6];
    assign sbox_req = w_run;
    assign sbox_sel = w_run ? r_k : 3'd0;
    assign sbox_in  = w_run ? {w_raw[0], w_raw[1], w_raw[2], w_raw[3], w_raw[4], w_raw[5]} : 6'd0;
    assign w_nib    = {sbox_out[0], sbox_out[1], sbox_out[2], sbox_out[3]};

    // With a registered S-box the result lands one cycle after its request.
    assign w_col_vld = (SBOX_LAT == 0) ? w_run : r_col_vld;
    assign w_col_sel = (SBOX_LAT == 0) ? r_k   : r_col_sel;

    always_comb begin
        w_dout_nxt = r_dout;
        if (w_col_vld)
            w_dout_nxt[{w_col_sel, 2'b00} +: 4] = w_nib;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_k       <= 3'd0;
            r_din     <= 48'd0;
            r_dout    <= 32'd0;
            r_col_vld <= 1'b0;
            r_col_sel <= 3'd0;
        end else begin
            r_col_vld <= w_run;
            r_col_sel <= r_k;
            r_dout    <= w_dout_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_din   <= din;
                        r_k     <= 3'd0;
                        r_dout  <= 32'd0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_k <= r_k + 3'd1;
                    if (r_k == 3'd7)
                        r_state <= (SBOX_LAT == 0) ? DONE : DRAIN;
                end
                DRAIN: r_state <= DONE;
                DONE: begin
                    // Output handshake and next capture may share one edge.
                    if (out_ready) begin
                        if (in_valid) begin
                            r_din   <= din;
                            r_k     <= 3'd0;
                            r_dout  <= 32'd0;
                            r_state <= RUN;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
